// File: rtl/float_triple_collector_pkg.sv
// rtl/float_triple_collector_pkg.sv - shared float width, pad constant, FSM states and key helpers
package float_triple_collector_pkg;

    localparam int FLEN  = 64;
    localparam int EXP_W = (FLEN == 32) ? 8 : 11;
    localparam int MAN_W = FLEN - 1 - EXP_W;

    // +infinity: sign 0, exponent all ones, mantissa 0
    localparam logic [FLEN-1:0] POS_INF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [1:0] {FILL, SORT, OUT} state_t;

    typedef logic [0:2][FLEN-1:0] triple_t;

    // Maps an IEEE float onto an unsigned key whose integer order matches the
    // numeric order of non-NaN values (-0 lands just below +0).
    function automatic logic [FLEN-1:0] sort_key(input logic [FLEN-1:0] x);
        sort_key = x[FLEN-1] ? ~x : {1'b1, x[FLEN-2:0]};
    endfunction

    function automatic logic is_nan(input logic [FLEN-1:0] x);
        is_nan = (&x[FLEN-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

endpackage

// File: rtl/sort_three_floats.sv
// rtl/sort_three_floats.sv - combinational ascending sort of three floats with NaN flag
//
// Ports:
//   in_data  three floats, any order
//   sorted   ascending, index 0 smallest
//   err      any operand is NaN (ordering of the outputs is then meaningless)
module sort_three_floats
    import float_triple_collector_pkg::*;
(
    input  triple_t in_data,
    output triple_t sorted,
    output logic    err
);

    triple_t          s;
    logic [FLEN-1:0]  t;

    // Three-step bubble network swapping only on strict greater-than, so equal
    // keys keep their input order: a real +inf at a lower slot stays ahead of pads.
    always_comb begin
        s = in_data;
        t = '0;
        if (sort_key(s[0]) > sort_key(s[1])) begin
            t = s[0]; s[0] = s[1]; s[1] = t;
        end
        if (sort_key(s[1]) > sort_key(s[2])) begin
            t = s[1]; s[1] = s[2]; s[2] = t;
        end
        if (sort_key(s[0]) > sort_key(s[1])) begin
            t = s[0]; s[0] = s[1]; s[1] = t;
        end
        sorted = s;
        err    = is_nan(in_data[0]) | is_nan(in_data[1]) | is_nan(in_data[2]);
    end

endmodule

// File: rtl/float_triple_collector.sv
// rtl/float_triple_collector.sv - packs streamed floats into triples, sorts and presents them
//
// Float width FLEN comes from float_triple_collector_pkg.
// Optional macro FLOAT_TRIPLE_ERR_DROP_EN: triples with a NaN operand are discarded
// and down_err is tied to 0.
//
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   up_valid/up_ready     input beat handshake, up_data float, up_last closes group
//   down_valid/down_ready output triple handshake
//   down_data             sorted triple, index 0 smallest
//   down_count            real elements in the triple (1..3), rest are +inf pads
//   down_err              sorter saw a NaN operand
module float_triple_collector
    import float_triple_collector_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            up_valid,
    output logic            up_ready,
    input  logic [FLEN-1:0] up_data,
    input  logic            up_last,
    output logic            down_valid,
    input  logic            down_ready,
    output triple_t         down_data,
    output logic [1:0]      down_count,
    output logic            down_err
);

    state_t     state_q, state_d;
    logic [1:0] cnt_q;
    logic [1:0] n_q;
    triple_t    buf_q;
    triple_t    down_data_q;
    logic [1:0] down_count_q;
    logic       down_valid_q;
    triple_t    sorted;
    logic       sort_err;
    logic       accept;
    logic       close;

    sort_three_floats u_sort (
        .in_data (buf_q),
        .sorted  (sorted),
        .err     (sort_err)
    );

    assign up_ready = rst && (state_q == FILL);
    assign accept   = up_valid && up_ready;
    assign close    = accept && ((cnt_q == 2'd2) || up_last);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (close) state_d = SORT;
`ifdef FLOAT_TRIPLE_ERR_DROP_EN
            SORT: state_d = sort_err ? FILL : OUT;
`else
            SORT: state_d = OUT;
`endif
            OUT:  if (down_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            n_q          <= '0;
            buf_q        <= '0;
            down_data_q  <= '0;
            down_count_q <= '0;
            down_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            down_valid_q <= (state_d == OUT);
            if (accept) begin
                // Write the beat into its slot; a closing beat also pads every slot above it.
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == cnt_q)
                        buf_q[i] <= up_data;
                    else if (close && (2'(i) > cnt_q))
                        buf_q[i] <= POS_INF;
                end
                if (close) begin
                    n_q   <= cnt_q + 2'd1;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                end
            end
            if (state_q == SORT) begin
                down_data_q  <= sorted;
                down_count_q <= n_q;
            end
        end
    end

`ifdef FLOAT_TRIPLE_ERR_DROP_EN
    assign down_err = 1'b0;
`else
    logic down_err_q;

    always_ff @(posedge clk) begin
        if (!rst)
            down_err_q <= 1'b0;
        else if (state_q == SORT)
            down_err_q <= sort_err;
    end

    assign down_err = down_err_q;
`endif

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_count = down_count_q;

endmodule

// File: tb/tb_float_triple_collector.sv
// tb/tb_float_triple_collector.sv - directed self-checking bench for float_triple_collector
module tb_float_triple_collector;
    import float_triple_collector_pkg::*;

    localparam logic [63:0] F_M1   = 64'hBFF0000000000000;
    localparam logic [63:0] F_1    = 64'h3FF0000000000000;
    localparam logic [63:0] F_2    = 64'h4000000000000000;
    localparam logic [63:0] F_3    = 64'h4008000000000000;
    localparam logic [63:0] F_5    = 64'h4014000000000000;
    localparam logic [63:0] F_NAN  = 64'h7FF8000000000000;
    localparam logic [63:0] F_INF  = 64'h7FF0000000000000;

    logic            clk;
    logic            rst;
    logic            up_valid;
    logic            up_ready;
    logic [FLEN-1:0] up_data;
    logic            up_last;
    logic            down_valid;
    logic            down_ready;
    triple_t         down_data;
    logic [1:0]      down_count;
    logic            down_err;

    int checks   = 0;
    int failures = 0;

    float_triple_collector dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_last    (up_last),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_count (down_count),
        .down_err   (down_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_triple(input string tag, input logic [63:0] e0,
                              input logic [63:0] e1, input logic [63:0] e2,
                              input logic [1:0] ecnt, input logic eerr);
        chk({tag, "_valid"}, 64'(down_valid), 64'd1);
        chk({tag, "_d0"}, down_data[0], e0);
        chk({tag, "_d1"}, down_data[1], e1);
        chk({tag, "_d2"}, down_data[2], e2);
        chk({tag, "_count"}, 64'(down_count), 64'(ecnt));
        chk({tag, "_err"}, 64'(down_err), 64'(eerr));
    endtask

    task automatic send(input logic [63:0] d, input logic last);
        up_valid = 1'b1;
        up_data  = d;
        up_last  = last;
        step();
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        up_last    = 1'b0;
        down_ready = 1'b1;
        step();
        step();
        chk("rst_up_ready", 64'(up_ready), 64'd0);
        chk("rst_down_valid", 64'(down_valid), 64'd0);
        chk("rst_down_data0", down_data[0], 64'd0);
        chk("rst_down_count", 64'(down_count), 64'd0);
        chk("rst_down_err", 64'(down_err), 64'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_up_ready", 64'(up_ready), 64'd1);

        // Full group, back-to-back
        send(F_3, 1'b0);
        send(F_M1, 1'b0);
        send(F_2, 1'b0);
        chk("full_sort_valid", 64'(down_valid), 64'd0);
        chk("full_sort_ready", 64'(up_ready), 64'd0);
        step();
        chk_triple("full", F_M1, F_2, F_3, 2'd3, 1'b0);
        step();
        chk("full_after_valid", 64'(down_valid), 64'd0);
        chk("full_after_ready", 64'(up_ready), 64'd1);

        // Short group closed by up_last
        send(F_5, 1'b0);
        send(F_1, 1'b1);
        step();
        chk_triple("short", F_1, F_5, F_INF, 2'd2, 1'b0);
        step();

        // Real +inf ahead of pads
        send(F_INF, 1'b1);
        step();
        chk_triple("inf1", F_INF, F_INF, F_INF, 2'd1, 1'b0);
        step();

        // Backpressure, with an offered beat that must not be taken
        down_ready = 1'b0;
        send(F_2, 1'b0);
        send(F_1, 1'b0);
        send(F_3, 1'b0);
        step();
        up_valid = 1'b1;
        up_data  = F_NAN;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(down_valid), 64'd1);
            chk("bp_d0", down_data[0], F_1);
            chk("bp_d2", down_data[2], F_3);
            chk("bp_ready", 64'(up_ready), 64'd0);
            step();
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(down_valid), 64'd0);
        chk("bp_release_ready", 64'(up_ready), 64'd1);
        chk("bp_hold_d1", down_data[1], F_2);

        // NaN operand
        send(F_1, 1'b0);
        send(F_NAN, 1'b0);
        send(F_2, 1'b0);
        step();
`ifdef FLOAT_TRIPLE_ERR_DROP_EN
        chk("nan_drop_valid", 64'(down_valid), 64'd0);
        chk("nan_drop_ready", 64'(up_ready), 64'd1);
        send(F_M1, 1'b0);
        send(F_3, 1'b0);
        send(F_2, 1'b0);
        step();
        chk_triple("after_nan", F_M1, F_2, F_3, 2'd3, 1'b0);
`else
        chk("nan_valid", 64'(down_valid), 64'd1);
        chk("nan_err", 64'(down_err), 64'd1);
        chk("nan_count", 64'(down_count), 64'd3);
`endif
        step();

        // Reset after two accepts discards the partial group
        send(F_1, 1'b0);
        send(F_2, 1'b0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(down_valid), 64'd0);
        chk("mid_rst_ready", 64'(up_ready), 64'd1);
        send(F_5, 1'b0);
        send(F_3, 1'b0);
        send(F_1, 1'b1);
        chk("fresh_sort_valid", 64'(down_valid), 64'd0);
        step();
        chk_triple("fresh", F_1, F_3, F_5, 2'd3, 1'b0);
        step();

        // Idle with up_last but no up_valid, mid-group
        send(F_2, 1'b0);
        up_last = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_ready", 64'(up_ready), 64'd1);
            chk("idle_valid", 64'(down_valid), 64'd0);
        end
        up_last = 1'b0;
        send(F_1, 1'b0);
        send(F_3, 1'b0);
        step();
        chk_triple("idle_group", F_1, F_2, F_3, 2'd3, 1'b0);
        step();
        chk("end_valid", 64'(down_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
